// File: rtl/receiver_pkg.sv
// Shared UART receive definitions: FSM encoding, frame constants and the
// parity helper also used by the transmitter's parity generator.
package receiver_pkg;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned DEF_SAMPLE_DIV     = 326;
    localparam int unsigned DEF_OVERSAMPLE     = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Parity bit that makes the frame's total count of ones even (odd = 0) or odd (odd = 1).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/receiver_fsm.sv
// Receive sequencer: oversample tick and sample counters, frame state machine,
// and single-cycle sample strobes for the datapath in the top.
module receiver_fsm
    import receiver_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic busy,
    output logic shift_c,
    output logic parity_c,
    output logic stop_c
);

    localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);

    rx_state_e         state_q, state_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]     samp_cnt_q, samp_cnt_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic              tick_c;
    logic              mid_start_c;
    logic              mid_bit_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            busy       <= (state_d != ST_IDLE);
        end
    end

    assign tick_c      = (tick_cnt_q == TW'(SAMPLE_DIV - 1));
    assign mid_start_c = tick_c && (samp_cnt_q == SW'(OVERSAMPLE / 2 - 1));
    assign mid_bit_c   = tick_c && (samp_cnt_q == SW'(OVERSAMPLE - 1));

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_c    = 1'b0;
        parity_c   = 1'b0;
        stop_c     = 1'b0;
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);
        samp_cnt_d = samp_cnt_q;
        if (tick_c) begin
            samp_cnt_d = (samp_cnt_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt_q + SW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Holding counters at zero aligns tick phase to the start edge.
                tick_cnt_d = '0;
                samp_cnt_d = '0;
                bit_idx_d  = '0;
                if (!line) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mid_start_c) begin
                    if (!line) begin
                        // Restart the sample count so the next mid-bit is one full bit away.
                        samp_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (mid_bit_c) begin
                    shift_c = 1'b1;
                    if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (mid_bit_c) begin
                    parity_c = 1'b1;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mid_bit_c) begin
                    stop_c  = 1'b1;
                    state_d = line ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (line) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/receiver.sv
// UART receiver top: input synchronizer, data shift register, parity/stop
// evaluation and registered byte/strobe/error outputs.
module receiver
    import receiver_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 even_odd,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    logic [1:0]           sync_q;
    logic                 line;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 shift_c;
    logic                 parity_c;
    logic                 stop_c;

    assign line = sync_q[1];

    receiver_fsm #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_fsm (
        .clk      (sys_clk),
        .rst      (rst),
        .line     (line),
        .busy     (busy),
        .shift_c  (shift_c),
        .parity_c (parity_c),
        .stop_c   (stop_c)
    );

    // Synchronizer resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            shift_q    <= '0;
            par_q      <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], serial_in};
            rx_valid <= stop_c;
            if (shift_c) begin
                shift_q <= {line, shift_q[DATA_BITS-1:1]};
            end
            if (parity_c) begin
                par_q <= line;
            end
            if (stop_c) begin
                rx_data    <= shift_q;
                parity_err <= (par_q != parity_bit(shift_q, even_odd));
                frame_err  <= ~line;
            end
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: serial frames are driven bit by bit, the
// expected byte/flags are queued, and a monitor checks every rx_valid strobe.
module tb_receiver;

    localparam int unsigned SDIV = 4;
    localparam int unsigned OS   = 16;
    localparam int          BIT  = SDIV * OS;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       even_odd;
    logic       serial_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int   total   = 0;
    int   bad     = 0;
    int   strobes = 0;
    int   exp_strobes = 0;
    exp_t exp_q[$];
    logic [7:0] last_d = 8'h00;

    receiver #(
        .SAMPLE_DIV (SDIV),
        .OVERSAMPLE (OS)
    ) dut (
        .sys_clk    (clk),
        .rst        (rst),
        .even_odd   (even_odd),
        .serial_in  (serial_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Consumer side: every strobe must match the oldest queued frame.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got rx_data=%0h, expected no strobe (t=%0t)", rx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.d));
                    check("parity_err", 32'(parity_err), 32'(e.pe));
                    check("frame_err", 32'(frame_err), 32'(e.fe));
                end
            end
        end
    endtask

    // Reference: parity is good when the ones count of data+parity matches the selected sense.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int low_hold);
        exp_t e;
        e.d  = d;
        e.pe = (($countones({d, par}) % 2) == 1) != even_odd;
        e.fe = ~stp;
        exp_q.push_back(e);
        exp_strobes++;
        last_d = d;
        serial_in = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            wait_cyc(BIT);
        end
        serial_in = par;
        wait_cyc(BIT);
        serial_in = stp;
        wait_cyc(BIT);
        if (!stp) begin
            wait_cyc(low_hold);
            serial_in = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp;
        logic       rs;
        int         gap;

        rst       = 1'b1;
        serial_in = 1'b1;
        even_odd  = 1'b0;
        fork
            monitor();
        join_none
        wait_cyc(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_cyc(10);

        // Good frame 0xA5 with even parity.
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        check("good_strobes", 32'(strobes), 32'(exp_strobes));
        check("good_busy_after_stop", 32'(busy), 32'h0);
        wait_cyc(20);

        // Same frame, wrong parity bit.
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        check("perr_strobes", 32'(strobes), 32'(exp_strobes));
        wait_cyc(20);

        // Short low glitch must not start a frame.
        serial_in = 1'b0;
        wait_cyc(20);
        serial_in = 1'b1;
        wait_cyc(40);
        check("glitch_busy", 32'(busy), 32'h0);
        check("glitch_strobes", 32'(strobes), 32'(exp_strobes));

        // Framing error with the line left low (break).
        send_frame(8'h3C, 1'b0, 1'b0, 200);
        check("ferr_busy_while_low", 32'(busy), 32'h1);
        wait_cyc(10);
        check("ferr_busy_after_high", 32'(busy), 32'h0);
        check("ferr_strobes", 32'(strobes), 32'(exp_strobes));
        wait_cyc(20);

        // Back-to-back frames, odd parity, no idle gap.
        even_odd = 1'b1;
        send_frame(8'h00, 1'b1, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 1'b1, 0);
        check("b2b_strobes", 32'(strobes), 32'(exp_strobes));
        check("b2b_hold_rx_data", 32'(rx_data), 32'hFF);

        // Reset in the middle of a frame's data bits.
        serial_in = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'(i % 2);
            wait_cyc(BIT);
        end
        rst       = 1'b1;
        serial_in = 1'b1;
        wait_cyc(2);
        check_reset_outputs("midreset");
        rst = 1'b0;
        wait_cyc(2 * BIT);
        check("midreset_strobes", 32'(strobes), 32'(exp_strobes));
        check("midreset_busy", 32'(busy), 32'h0);

        // Randomized frames with random parity sense, parity bit and stop errors.
        for (int n = 0; n < 24; n++) begin
            rd       = 8'($urandom);
            rp       = 1'($urandom);
            rs       = ($urandom_range(0, 3) != 0);
            even_odd = 1'($urandom);
            send_frame(rd, rp, rs, int'($urandom_range(0, 100)));
            gap = rs ? int'($urandom_range(0, 80)) : int'($urandom_range(8, 80));
            wait_cyc(gap);
        end
        wait_cyc(BIT);
        check("rand_strobes", 32'(strobes), 32'(exp_strobes));
        check("rand_hold_rx_data", 32'(rx_data), 32'(last_d));
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
